// File: rtl/fifo_bank_if.sv
// rtl/fifo_bank_if.sv - handshake/data bundle between a fifo_bank and its client
interface fifo_bank_if #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int CW       = 4
);
    logic [CHANNELS-1:0]       push_i;
    logic [CHANNELS-1:0]       pop_i;
    logic [CHANNELS*WIDTH-1:0] dato_i;
    logic                      clr_err_i;
    logic [CHANNELS*WIDTH-1:0] dato_o;
    logic [CHANNELS-1:0]       full_o;
    logic [CHANNELS-1:0]       empty_o;
    logic [CHANNELS-1:0]       afull_o;
    logic [CHANNELS*CW-1:0]    count_o;
    logic [CHANNELS-1:0]       ovf_o;
    logic [CHANNELS-1:0]       udf_o;

    modport slave (
        input  push_i, pop_i, dato_i, clr_err_i,
        output dato_o, full_o, empty_o, afull_o, count_o, ovf_o, udf_o
    );

    modport master (
        output push_i, pop_i, dato_i, clr_err_i,
        input  dato_o, full_o, empty_o, afull_o, count_o, ovf_o, udf_o
    );
endinterface

// File: rtl/fifo_bank.sv
// rtl/fifo_bank.sv - CHANNELS independent FWFT queues; FIFO_BANK_OVERWRITE_EN selects overwrite-oldest on full push
module fifo_bank #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 8,
    parameter int CHANNELS  = 4,
    parameter int AFULL_LVL = DEPTH - 2
) (
    input  logic        clk,
    input  logic        rst_n,
    fifo_bank_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [WIDTH-1:0] r_mem [DEPTH];
        logic [PW-1:0]    r_wr;
        logic [PW-1:0]    r_rd;
        logic [CW-1:0]    r_cnt;
        logic             r_ovf;
        logic             r_udf;

        logic w_push, w_pop, w_full, w_empty;
        logic w_do_push, w_do_pop, w_ovw;
        logic w_ovf_evt, w_udf_evt;

        assign w_push    = bus.push_i[c];
        assign w_pop     = bus.pop_i[c];
        assign w_full    = (r_cnt == CW'(DEPTH));
        assign w_empty   = (r_cnt == '0);
        assign w_do_pop  = w_pop & ~w_empty;
        assign w_ovf_evt = w_push & w_full & ~w_pop;
        assign w_udf_evt = w_pop & w_empty;

`ifdef FIFO_BANK_OVERWRITE_EN
        // A full push without pop evicts the head, so the read pointer moves too.
        assign w_ovw     = w_ovf_evt;
        assign w_do_push = w_push;
`else
        assign w_ovw     = 1'b0;
        assign w_do_push = w_push & (~w_full | w_pop);
`endif

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
                r_wr  <= '0;
                r_rd  <= '0;
                r_cnt <= '0;
                r_ovf <= 1'b0;
                r_udf <= 1'b0;
            end else begin
                if (w_do_push) begin
                    r_mem[r_wr] <= bus.dato_i[c*WIDTH +: WIDTH];
                    r_wr        <= (r_wr == PW'(DEPTH - 1)) ? '0 : r_wr + 1'b1;
                end
                if (w_do_pop | w_ovw)
                    r_rd <= (r_rd == PW'(DEPTH - 1)) ? '0 : r_rd + 1'b1;
                r_cnt <= r_cnt + CW'(w_do_push) - CW'(w_do_pop) - CW'(w_ovw);
                // A new event wins over a simultaneous clear.
                if (w_ovf_evt)          r_ovf <= 1'b1;
                else if (bus.clr_err_i) r_ovf <= 1'b0;
                if (w_udf_evt)          r_udf <= 1'b1;
                else if (bus.clr_err_i) r_udf <= 1'b0;
            end
        end

        assign bus.dato_o[c*WIDTH +: WIDTH] = r_mem[r_rd];
        assign bus.count_o[c*CW +: CW]      = r_cnt;
        assign bus.full_o[c]                = w_full;
        assign bus.empty_o[c]               = w_empty;
        assign bus.afull_o[c]               = (r_cnt >= CW'(AFULL_LVL));
        assign bus.ovf_o[c]                 = r_ovf;
        assign bus.udf_o[c]                 = r_udf;
    end
endmodule

// File: tb/tb_fifo_bank.sv
// tb/tb_fifo_bank.sv - directed self-checking bench for fifo_bank
module tb_fifo_bank;
    localparam int W  = 16;
    localparam int D  = 8;
    localparam int C  = 4;
    localparam int CWL = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    fifo_bank_if #(.WIDTH(W), .CHANNELS(C), .CW(CWL)) bus ();

    fifo_bank #(.WIDTH(W), .DEPTH(D), .CHANNELS(C), .AFULL_LVL(D - 2)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [W-1:0] dat(input int c);
        return bus.dato_o[c*W +: W];
    endfunction

    function automatic logic [CWL-1:0] cnt(input int c);
        return bus.count_o[c*CWL +: CWL];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int c, input logic [W-1:0] v);
        bus.dato_i[c*W +: W] = v;
    endtask

    task automatic check_reset_state(input string tag);
        n_total++; if (bus.dato_o !== '0) $display("FAIL %s_dato got=%h exp=0", tag, bus.dato_o); else n_pass++;
        n_total++; if (bus.count_o !== '0) $display("FAIL %s_count got=%h exp=0", tag, bus.count_o); else n_pass++;
        n_total++; if (bus.empty_o !== 4'hF) $display("FAIL %s_empty got=%h exp=f", tag, bus.empty_o); else n_pass++;
        n_total++; if (bus.full_o !== 4'h0) $display("FAIL %s_full got=%h exp=0", tag, bus.full_o); else n_pass++;
        n_total++; if (bus.afull_o !== 4'h0) $display("FAIL %s_afull got=%h exp=0", tag, bus.afull_o); else n_pass++;
        n_total++; if (bus.ovf_o !== 4'h0) $display("FAIL %s_ovf got=%h exp=0", tag, bus.ovf_o); else n_pass++;
        n_total++; if (bus.udf_o !== 4'h0) $display("FAIL %s_udf got=%h exp=0", tag, bus.udf_o); else n_pass++;
    endtask

    task automatic test_reset();
        bus.push_i = '0; bus.pop_i = '0; bus.dato_i = '0; bus.clr_err_i = 1'b0;
        rst_n = 1'b0;
        step(); step();
        check_reset_state("reset");
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        bus.push_i = 4'b0001;
        set_data(0, 16'h0006); step();
        set_data(0, 16'h000A); step();
        bus.push_i = '0;
        n_total++; if (cnt(0) !== 4'd2) $display("FAIL basic_count got=%0d exp=2", cnt(0)); else n_pass++;
        n_total++; if (dat(0) !== 16'h0006) $display("FAIL basic_head got=%h exp=0006", dat(0)); else n_pass++;
        bus.pop_i = 4'b0001; step(); bus.pop_i = '0;
        n_total++; if (dat(0) !== 16'h000A) $display("FAIL basic_pop1 got=%h exp=000a", dat(0)); else n_pass++;
        n_total++; if (cnt(0) !== 4'd1) $display("FAIL basic_count1 got=%0d exp=1", cnt(0)); else n_pass++;
        bus.pop_i = 4'b0001; step(); bus.pop_i = '0;
        n_total++; if (bus.empty_o[0] !== 1'b1) $display("FAIL basic_empty got=%b exp=1", bus.empty_o[0]); else n_pass++;
        n_total++; if (cnt(0) !== 4'd0) $display("FAIL basic_count0 got=%0d exp=0", cnt(0)); else n_pass++;
        n_total++; if (bus.udf_o[0] !== 1'b0) $display("FAIL basic_udf got=%b exp=0", bus.udf_o[0]); else n_pass++;
    endtask

    task automatic test_fill_overflow();
        logic [W-1:0] base;
`ifdef FIFO_BANK_OVERWRITE_EN
        base = 16'h0101;
`else
        base = 16'h0100;
`endif
        for (int i = 0; i < D; i++) begin
            bus.push_i = 4'b0010;
            set_data(1, 16'h0100 + 16'(i));
            step();
            n_total++; if (bus.afull_o[1] !== (i + 1 >= 6)) $display("FAIL fill_afull%0d got=%b", i, bus.afull_o[1]); else n_pass++;
            n_total++; if (bus.full_o[1] !== (i == D - 1)) $display("FAIL fill_full%0d got=%b", i, bus.full_o[1]); else n_pass++;
            n_total++; if (cnt(1) !== 4'(i + 1)) $display("FAIL fill_count%0d got=%0d exp=%0d", i, cnt(1), i + 1); else n_pass++;
        end
        set_data(1, 16'h0108); step();
        bus.push_i = '0;
        n_total++; if (bus.ovf_o[1] !== 1'b1) $display("FAIL ovf_set got=%b exp=1", bus.ovf_o[1]); else n_pass++;
        n_total++; if (cnt(1) !== 4'd8) $display("FAIL ovf_count got=%0d exp=8", cnt(1)); else n_pass++;
        n_total++; if (dat(1) !== base) $display("FAIL ovf_head got=%h exp=%h", dat(1), base); else n_pass++;
        for (int i = 0; i < D; i++) begin
            n_total++; if (dat(1) !== base + 16'(i)) $display("FAIL drain%0d got=%h exp=%h", i, dat(1), base + 16'(i)); else n_pass++;
            bus.pop_i = 4'b0010; step();
        end
        bus.pop_i = '0;
        n_total++; if (bus.empty_o[1] !== 1'b1) $display("FAIL drain_empty got=%b exp=1", bus.empty_o[1]); else n_pass++;
        n_total++; if (bus.ovf_o[1] !== 1'b1) $display("FAIL ovf_sticky got=%b exp=1", bus.ovf_o[1]); else n_pass++;
    endtask

    task automatic test_underflow();
        bus.pop_i = 4'b0100; step(); bus.pop_i = '0;
        n_total++; if (bus.udf_o[2] !== 1'b1) $display("FAIL udf_set got=%b exp=1", bus.udf_o[2]); else n_pass++;
        n_total++; if (cnt(2) !== 4'd0) $display("FAIL udf_count got=%0d exp=0", cnt(2)); else n_pass++;
        bus.push_i = 4'b0100; bus.pop_i = 4'b0100; set_data(2, 16'h00FF); step();
        bus.push_i = '0; bus.pop_i = '0;
        n_total++; if (cnt(2) !== 4'd1) $display("FAIL pp_empty_count got=%0d exp=1", cnt(2)); else n_pass++;
        n_total++; if (dat(2) !== 16'h00FF) $display("FAIL pp_empty_head got=%h exp=00ff", dat(2)); else n_pass++;
        bus.clr_err_i = 1'b1; step(); bus.clr_err_i = 1'b0;
        n_total++; if (bus.udf_o !== 4'h0) $display("FAIL clr_udf got=%h exp=0", bus.udf_o); else n_pass++;
        n_total++; if (bus.ovf_o !== 4'h0) $display("FAIL clr_ovf got=%h exp=0", bus.ovf_o); else n_pass++;
        bus.pop_i = 4'b0100; step(); bus.pop_i = '0;
        n_total++; if (bus.empty_o[2] !== 1'b1 || bus.udf_o[2] !== 1'b0) $display("FAIL udf_pop1 empty=%b udf=%b exp=1/0", bus.empty_o[2], bus.udf_o[2]); else n_pass++;
        bus.pop_i = 4'b0100; bus.clr_err_i = 1'b1; step(); bus.pop_i = '0; bus.clr_err_i = 1'b0;
        n_total++; if (bus.udf_o[2] !== 1'b1) $display("FAIL clr_vs_evt got=%b exp=1", bus.udf_o[2]); else n_pass++;
        bus.clr_err_i = 1'b1; step(); bus.clr_err_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] q[$];
        for (int i = 0; i < D; i++) begin
            bus.push_i = 4'b1000; set_data(3, 16'h0300 + 16'(i)); step();
            q.push_back(16'h0300 + 16'(i));
        end
        for (int k = 0; k < 20; k++) begin
            n_total++; if (dat(3) !== q[0]) $display("FAIL b2b_head%0d got=%h exp=%h", k, dat(3), q[0]); else n_pass++;
            bus.push_i = 4'b1000; bus.pop_i = 4'b1000; set_data(3, 16'h0AAA); step();
            void'(q.pop_front()); q.push_back(16'h0AAA);
            n_total++; if (cnt(3) !== 4'd8) $display("FAIL b2b_count%0d got=%0d exp=8", k, cnt(3)); else n_pass++;
        end
        bus.push_i = '0; bus.pop_i = '0;
        n_total++; if (bus.ovf_o[3] !== 1'b0) $display("FAIL b2b_ovf got=%b exp=0", bus.ovf_o[3]); else n_pass++;
        for (int i = 0; i < D; i++) begin
            n_total++; if (dat(3) !== q[i]) $display("FAIL b2b_drain%0d got=%h exp=%h", i, dat(3), q[i]); else n_pass++;
            bus.pop_i = 4'b1000; step();
        end
        bus.pop_i = '0;
        n_total++; if (bus.empty_o[3] !== 1'b1) $display("FAIL b2b_empty got=%b exp=1", bus.empty_o[3]); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bus.push_i = 4'hF;
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < C; c++) set_data(c, 16'h1000 * 16'(c + 1) + 16'(k));
            step();
        end
        n_total++; if (bus.count_o !== 16'h3333) $display("FAIL mid_traffic got=%h exp=3333", bus.count_o); else n_pass++;
        rst_n = 1'b0;
        #1;
        check_reset_state("midrst");
        bus.push_i = '0;
        step();
        rst_n = 1'b1;
        bus.push_i = 4'b0001; set_data(0, 16'h0055); step(); bus.push_i = '0;
        n_total++; if (bus.count_o !== 16'h0001) $display("FAIL post_rst_count got=%h exp=0001", bus.count_o); else n_pass++;
        n_total++; if (dat(0) !== 16'h0055) $display("FAIL post_rst_head got=%h exp=0055", dat(0)); else n_pass++;
        n_total++; if (bus.empty_o !== 4'b1110) $display("FAIL post_rst_empty got=%b exp=1110", bus.empty_o); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill_overflow();
        test_underflow();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/fifo_bank.md
# fifo_bank

Multi-channel synchronous FIFO bank: CHANNELS independent first-word-fall-through queues of WIDTH x DEPTH behind one clock. It is the parametrised RTL successor to the single-channel push/pop FIFO and serves as the per-device buffer array of the bus emulator, one channel per attached device. It adds per-channel occupancy counts, almost-full flags, sticky overflow/underflow error flags and an optional overwrite-oldest mode.

## Interface
- WIDTH, 16, data bits per entry
- DEPTH, 8, entries per channel (>= 2; need not be a power of two)
- CHANNELS, 4, number of independent queues (>= 1)
- AFULL_LVL, DEPTH-2, count at or above which afull_o asserts (1..DEPTH)
- CW (localparam), $clog2(DEPTH+1), count width

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- push_i  in  CHANNELS  per-channel write strobe, one entry per cycle high
- pop_i  in  CHANNELS  per-channel read strobe, removes head entry
- dato_i  in  CHANNELS*WIDTH  write data; channel c at [c*WIDTH +: WIDTH]
- dato_o  out  CHANNELS*WIDTH  head entry of each channel (FWFT)
- full_o  out  CHANNELS  count == DEPTH
- empty_o  out  CHANNELS  count == 0
- afull_o  out  CHANNELS  count >= AFULL_LVL
- count_o  out  CHANNELS*CW  occupancy; channel c at [c*CW +: CW]
- ovf_o  out  CHANNELS  sticky: push accepted-or-refused while full without pop
- udf_o  out  CHANNELS  sticky: pop while empty
- clr_err_i  in  1  synchronous clear of all ovf_o/udf_o bits

## Operation
- Per channel: storage array, write pointer, read pointer, count register; pointers wrap DEPTH-1 -> 0.
- Push when not full: store dato_i at wr_ptr, wr_ptr++, count++.
- Pop when not empty: rd_ptr++, count--.
- Push and pop same cycle, 0 < count < DEPTH: both performed, count unchanged.
- Push and pop same cycle, count == DEPTH: both performed (pop frees slot), count stays DEPTH, ovf not set.
- Push and pop same cycle, count == 0: push performed, pop ignored, udf set, count -> 1.
- Pop when empty (no push): ignored, udf set.
- Push when full without pop: ovf set; behaviour per Configuration.
- Error flags: set on event, held until clr_err_i or reset; clr_err_i and a new event in the same cycle -> flag ends set.
- dato_o while empty: holds the storage word at rd_ptr (stale, not X after reset since storage resets to 0); consumers must qualify with empty_o.
- Channels are fully independent; no arbitration between them.

## Timing
- Reset (rst_n low, asynchronous): all pointers/counts 0, storage 0; dato_o = 0, count_o = 0, empty_o = all 1, full_o = 0, afull_o = 0, ovf_o = 0, udf_o = 0.
- Reset asserted mid-operation discards all contents immediately; deassertion takes effect on the next rising edge (release synchronised externally).
- Push at edge k: count_o, flags update after edge k; if queue was empty, dato_o shows the word after edge k (1-cycle write-to-read latency).
- Pop at edge k: dato_o shows next entry after edge k.
- All outputs are functions of registers only; no combinational path from push_i/pop_i/dato_i to any output.
- Sustained throughput: one push and one pop per channel per cycle.

## Configuration
- FIFO_BANK_OVERWRITE_EN defined: push when full without pop overwrites the oldest entry — write at wr_ptr, wr_ptr++, rd_ptr++, count stays DEPTH, ovf set; dato_o advances to the next-oldest entry.
- Undefined (default): push when full without pop is dropped; storage, pointers and count unchanged; ovf set.

## Test plan
- Reset then push 0x0006, 0x000A on ch0 -> after 2nd edge count=2, dato_o[ch0]=0x0006; pop -> 0x000A; pop -> empty_o[0]=1, count=0.
- Fill ch1 with 0x0100..0x0107 (DEPTH=8) -> afull_o[1] at count 6, full_o[1] at 8; 9th push 0x0108 -> ovf_o[1]=1; default: dato_o[ch1]=0x0100, drain yields 0x0100..0x0107; with FIFO_BANK_OVERWRITE_EN: dato_o=0x0101, drain yields 0x0101..0x0108.
- Pop empty ch2 -> udf_o[2]=1, count 0; simultaneous push 0x00FF + pop on empty ch2 -> count=1, dato_o=0x00FF; clr_err_i -> udf_o=0.
- Full ch3, push 0x0AAA + pop same cycle for 20 cycles -> count stays 8, no ovf, output order preserved across pointer wrap.
- Traffic on all channels with distinct data, assert rst_n low mid-burst -> all outputs at reset values immediately; subsequent pushes start clean.
